// File: rtl/nbin_pkg.sv
// nbin_pkg: sizing defaults and grant encoding shared by the NBin/NBout SRAM path.
package nbin_pkg;
    localparam int NBIN_N         = 256;
    localparam int NBIN_ADDR      = 6;
    localparam int NBIN_NUM_WORDS = 64;
    localparam int NBIN_RD_DEPTH  = 4;
    typedef enum logic {GNT_WR = 1'b0, GNT_RD = 1'b1} grant_e;
endpackage

// File: rtl/nbin_rd_fifo.sv
// nbin_rd_fifo: synchronous read-return FIFO.
// The head word is presented combinationally whenever the FIFO is non-empty.
module nbin_rd_fifo import nbin_pkg::*; #(
    parameter int DEPTH = NBIN_RD_DEPTH,
    parameter int W     = NBIN_N
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [W-1:0]               data_i,
    input  logic                       pop_i,
    output logic [W-1:0]               data_o,
    output logic                       valid_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_pop;
    always_comb begin
        do_pop = pop_i && (cnt_q != '0);
        wp_d   = push_i ? ((wp_q == PW'(DEPTH - 1)) ? '0 : wp_q + PW'(1)) : wp_q;
        rp_d   = do_pop ? ((rp_q == PW'(DEPTH - 1)) ? '0 : rp_q + PW'(1)) : rp_q;
        cnt_d  = cnt_q + CW'(push_i) - CW'(do_pop);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wp_q] <= data_i;
    end
    assign data_o  = mem_q[rp_q];
    assign valid_o = cnt_q != '0;
    assign count_o = cnt_q;
endmodule

// File: rtl/nbin_sram_ctrl.sv
// nbin_sram_ctrl: arbitrates write and read requests onto a single-port SRAM
// and returns read data in order through a credit-limited FIFO.
module nbin_sram_ctrl import nbin_pkg::*; #(
    parameter int N         = NBIN_N,
    parameter int ADDR      = NBIN_ADDR,
    parameter int NUM_WORDS = NBIN_NUM_WORDS,
    parameter int RD_DEPTH  = NBIN_RD_DEPTH
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_wr_valid,
    output logic            o_wr_ready,
    input  logic [ADDR-1:0] i_wr_addr,
    input  logic [N-1:0]    i_wr_data,
    input  logic            i_rd_valid,
    output logic            o_rd_ready,
    input  logic [ADDR-1:0] i_rd_addr,
    output logic            o_rdata_valid,
    input  logic            i_rdata_ready,
    output logic [N-1:0]    o_rdata,
    output logic            o_cen,
    output logic            o_wen,
    output logic [ADDR-1:0] o_a,
    output logic [N-1:0]    o_d,
    input  logic [N-1:0]    i_q
);
    localparam int CW = $clog2(RD_DEPTH + 1);
    if (NUM_WORDS > (1 << ADDR)) begin : g_depth_chk
        $error("nbin_sram_ctrl: NUM_WORDS does not fit in ADDR bits");
    end
    logic [CW-1:0]   fifo_cnt;
    logic [CW:0]     used;
    logic            rd_elig, wr_gnt, rd_gnt;
    logic            cen_q, cen_d, wen_q, wen_d;
    logic [ADDR-1:0] a_q, a_d;
    logic [N-1:0]    d_q, d_d;
    logic            rd_s1_q, rd_s2_q;
    grant_e          last_q, last_d;
    // Credits cover words already queued plus reads still in the SRAM pipe.
    assign used = {1'b0, fifo_cnt} + (CW+1)'(rd_s1_q) + (CW+1)'(rd_s2_q);
    always_comb begin
        rd_elig = i_rd_valid && (used < (CW+1)'(RD_DEPTH));
        wr_gnt  = i_wr_valid && (!rd_elig || last_q == GNT_RD);
        rd_gnt  = rd_elig && !wr_gnt;
        cen_d   = !(wr_gnt || rd_gnt);
        wen_d   = !wr_gnt;
        a_d     = wr_gnt ? i_wr_addr : (rd_gnt ? i_rd_addr : a_q);
        d_d     = wr_gnt ? i_wr_data : d_q;
        last_d  = wr_gnt ? GNT_WR : (rd_gnt ? GNT_RD : last_q);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cen_q   <= 1'b1;
            wen_q   <= 1'b1;
            a_q     <= '0;
            d_q     <= '0;
            rd_s1_q <= 1'b0;
            rd_s2_q <= 1'b0;
            last_q  <= GNT_RD;
        end else begin
            cen_q   <= cen_d;
            wen_q   <= wen_d;
            a_q     <= a_d;
            d_q     <= d_d;
            rd_s1_q <= rd_gnt;
            rd_s2_q <= rd_s1_q;
            last_q  <= last_d;
        end
    end
    assign o_wr_ready = wr_gnt;
    assign o_rd_ready = rd_gnt;
    assign o_cen      = cen_q;
    assign o_wen      = wen_q;
    assign o_a        = a_q;
    assign o_d        = d_q;
    // i_q is valid in the cycle after the macro samples; rd_s2_q marks that cycle.
    nbin_rd_fifo #(.DEPTH(RD_DEPTH), .W(N)) u_rd_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (rd_s2_q),
        .data_i  (i_q),
        .pop_i   (i_rdata_ready),
        .data_o  (o_rdata),
        .valid_o (o_rdata_valid),
        .count_o (fifo_cnt)
    );
endmodule

// File: tb/tb_nbin_sram_ctrl.sv
// tb_nbin_sram_ctrl: bench for nbin_sram_ctrl with an SRAM model, a shadow memory
// and an in-order queue of expected read words.
module tb_nbin_sram_ctrl;
    localparam int N = 256, ADDR = 6, WORDS = 64, DEPTH = 4;
    logic clk = 1'b0, rst = 1'b1;
    logic i_wr_valid = 1'b0, i_rd_valid = 1'b0, i_rdata_ready = 1'b1;
    logic [ADDR-1:0] i_wr_addr = '0, i_rd_addr = '0;
    logic [N-1:0] i_wr_data = '0, i_q, q_q;
    logic o_wr_ready, o_rd_ready, o_rdata_valid, o_cen, o_wen;
    logic [ADDR-1:0] o_a;
    logic [N-1:0] o_rdata, o_d;
    logic [N-1:0] sram [WORDS];
    logic [N-1:0] shadow [WORDS];
    logic [N-1:0] exp_q [$];
    logic [N-1:0] stall_data, exp_w;
    logic stall_prev = 1'b0;
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    nbin_sram_ctrl dut (
        .clk(clk), .rst(rst),
        .i_wr_valid(i_wr_valid), .o_wr_ready(o_wr_ready), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data),
        .i_rd_valid(i_rd_valid), .o_rd_ready(o_rd_ready), .i_rd_addr(i_rd_addr),
        .o_rdata_valid(o_rdata_valid), .i_rdata_ready(i_rdata_ready), .o_rdata(o_rdata),
        .o_cen(o_cen), .o_wen(o_wen), .o_a(o_a), .o_d(o_d), .i_q(i_q)
    );

    // Single-port SRAM: output register updates the cycle after a sampled read.
    assign i_q = q_q;
    always @(posedge clk) begin
        if (!o_cen) begin
            if (!o_wen) sram[o_a] = o_d;
            else q_q <= sram[o_a];
        end
    end

    // Scoreboard: handshakes decided during this cycle take effect at the next edge.
    always @(negedge clk) begin
        if (rst) stall_prev = 1'b0;
        else begin
            if (stall_prev) begin
                total++;
                if (!o_rdata_valid || o_rdata !== stall_data) begin
                    bad++;
                    $display("FAIL hold: valid=%0b data=%h required valid=1 data=%h", o_rdata_valid, o_rdata, stall_data);
                end
            end
            if (o_rdata_valid && i_rdata_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL order: got unexpected word %h, required none", o_rdata);
                end else begin
                    exp_w = exp_q.pop_front();
                    if (o_rdata !== exp_w) begin
                        bad++;
                        $display("FAIL rdata: got %h required %h", o_rdata, exp_w);
                    end
                end
            end
            stall_prev = o_rdata_valid && !i_rdata_ready;
            stall_data = o_rdata;
            if (i_wr_valid && o_wr_ready) shadow[i_wr_addr] = i_wr_data;
            if (i_rd_valid && o_rd_ready) exp_q.push_back(shadow[i_rd_addr]);
        end
    end

    function automatic logic [N-1:0] rnd_word();
        logic [N-1:0] w;
        for (int i = 0; i < N / 32; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        i_wr_valid = 1'b0;
        i_rd_valid = 1'b0;
        i_rdata_ready = 1'b1;
        repeat (n) tick();
    endtask

    task automatic reset_dut();
        i_wr_valid = 1'b0;
        i_rd_valid = 1'b0;
        rst = 1'b1;
        exp_q.delete();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++;
        if (o_cen !== 1'b1 || o_wen !== 1'b1) begin
            bad++;
            $display("FAIL reset_en: cen=%0b wen=%0b required 1 1", o_cen, o_wen);
        end
        total++;
        if (o_a !== '0 || o_d !== '0) begin
            bad++;
            $display("FAIL reset_ad: a=%0d d=%h required 0 0", o_a, o_d);
        end
        total++;
        if (o_rdata_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_valid: got %0b required 0", o_rdata_valid);
        end
        tick();
        rst = 1'b0;
        i_wr_valid = 1'b1;
        i_rd_valid = 1'b1;
        i_wr_addr = 6'd0;
        i_wr_data = rnd_word();
        i_rd_addr = 6'd1;
        @(negedge clk);
        total++;
        if (o_wr_ready !== 1'b1 || o_rd_ready !== 1'b0) begin
            bad++;
            $display("FAIL first_grant: wr_ready=%0b rd_ready=%0b required 1 0", o_wr_ready, o_rd_ready);
        end
        tick();
        idle(6);
    endtask

    task automatic test_basic();
        logic [N-1:0] a5, x5a;
        int lat;
        a5 = {32{8'hA5}};
        x5a = {32{8'h5A}};
        i_wr_valid = 1'b1;
        i_wr_addr = 6'd3;
        i_wr_data = a5;
        @(negedge clk);
        total++;
        if (o_wr_ready !== 1'b1) begin
            bad++;
            $display("FAIL wr_ready: got %0b required 1", o_wr_ready);
        end
        tick();
        total++;
        if (o_cen !== 1'b0 || o_wen !== 1'b0 || o_a !== 6'd3 || o_d !== a5) begin
            bad++;
            $display("FAIL wr_port: cen=%0b wen=%0b a=%0d d=%h required 0 0 3 %h", o_cen, o_wen, o_a, o_d, a5);
        end
        i_wr_addr = 6'd7;
        i_wr_data = x5a;
        tick();
        i_wr_valid = 1'b0;
        i_rd_valid = 1'b1;
        i_rd_addr = 6'd3;
        @(negedge clk);
        total++;
        if (o_rd_ready !== 1'b1) begin
            bad++;
            $display("FAIL rd_ready: got %0b required 1", o_rd_ready);
        end
        tick();
        total++;
        if (o_cen !== 1'b0 || o_wen !== 1'b1 || o_a !== 6'd3) begin
            bad++;
            $display("FAIL rd_port: cen=%0b wen=%0b a=%0d required 0 1 3", o_cen, o_wen, o_a);
        end
        i_rd_addr = 6'd7;
        tick();
        i_rd_valid = 1'b0;
        // Handshake cycle of the first read is cycle 0; data must appear in cycle 3.
        lat = 1;
        while (!o_rdata_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        total++;
        if (lat != 3 || o_rdata !== a5) begin
            bad++;
            $display("FAIL latency: cycle=%0d data=%h required cycle 3 data %h", lat, o_rdata, a5);
        end
        @(negedge clk);
        total++;
        if (o_rdata_valid !== 1'b1 || o_rdata !== x5a) begin
            bad++;
            $display("FAIL second_read: valid=%0b data=%h required 1 %h", o_rdata_valid, o_rdata, x5a);
        end
        tick();
        idle(4);
    endtask

    task automatic test_alternate();
        reset_dut();
        i_rdata_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            i_wr_valid = 1'b1;
            i_rd_valid = 1'b1;
            i_wr_addr = ADDR'($urandom);
            i_wr_data = rnd_word();
            i_rd_addr = ADDR'($urandom);
            @(negedge clk);
            total++;
            if (o_wr_ready !== (k % 2 == 0) || o_rd_ready !== (k % 2 == 1)) begin
                bad++;
                $display("FAIL alternate_grant[%0d]: wr=%0b rd=%0b required wr=%0b", k, o_wr_ready, o_rd_ready, k % 2 == 0);
            end
            tick();
            total++;
            if (o_cen !== 1'b0 || o_wen !== (k % 2 == 1)) begin
                bad++;
                $display("FAIL alternate_wen[%0d]: cen=%0b wen=%0b required 0 %0b", k, o_cen, o_wen, k % 2 == 1);
            end
        end
        idle(6);
    endtask

    task automatic test_backpressure();
        int acc, cnt;
        logic [N-1:0] held;
        idle(6);
        acc = 0;
        i_rdata_ready = 1'b0;
        i_rd_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            i_rd_addr = ADDR'($urandom);
            @(negedge clk);
            if (o_rd_ready) acc++;
            tick();
        end
        total++;
        if (acc != DEPTH) begin
            bad++;
            $display("FAIL bp_accepts: got %0d required %0d", acc, DEPTH);
        end
        @(negedge clk);
        total++;
        if (o_rd_ready !== 1'b0) begin
            bad++;
            $display("FAIL bp_ready: got %0b required 0", o_rd_ready);
        end
        held = o_rdata;
        tick();
        tick();
        @(negedge clk);
        total++;
        if (o_rdata_valid !== 1'b1 || o_rdata !== held) begin
            bad++;
            $display("FAIL bp_hold: valid=%0b data=%h required 1 %h", o_rdata_valid, o_rdata, held);
        end
        tick();
        i_rd_valid = 1'b0;
        i_rdata_ready = 1'b1;
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (o_rdata_valid) cnt++;
            tick();
        end
        total++;
        if (cnt != DEPTH) begin
            bad++;
            $display("FAIL bp_drain: got %0d words required %0d", cnt, DEPTH);
        end
        i_rd_valid = 1'b1;
        i_rd_addr = ADDR'($urandom);
        @(negedge clk);
        total++;
        if (o_rd_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_resume: got %0b required 1", o_rd_ready);
        end
        tick();
        idle(6);
    endtask

    task automatic test_raw();
        logic [N-1:0] v;
        bit got;
        v = rnd_word();
        i_wr_valid = 1'b1;
        i_wr_addr = 6'd5;
        i_wr_data = v;
        @(negedge clk);
        total++;
        if (o_wr_ready !== 1'b1) begin
            bad++;
            $display("FAIL raw_wr: got %0b required 1", o_wr_ready);
        end
        tick();
        i_wr_valid = 1'b0;
        i_rd_valid = 1'b1;
        i_rd_addr = 6'd5;
        @(negedge clk);
        total++;
        if (o_rd_ready !== 1'b1) begin
            bad++;
            $display("FAIL raw_rd: got %0b required 1", o_rd_ready);
        end
        tick();
        i_rd_valid = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 8 && !got; k++) begin
            @(negedge clk);
            if (o_rdata_valid) begin
                got = 1'b1;
                total++;
                if (o_rdata !== v) begin
                    bad++;
                    $display("FAIL raw_data: got %h required %h", o_rdata, v);
                end
            end
        end
        total++;
        if (!got) begin
            bad++;
            $display("FAIL raw_timeout: got no data required one word");
        end
        tick();
        idle(4);
    endtask

    task automatic test_reset_mid();
        int seen;
        idle(4);
        i_rd_valid = 1'b1;
        i_rd_addr = ADDR'($urandom);
        tick();
        i_rd_addr = ADDR'($urandom);
        tick();
        i_rd_valid = 1'b0;
        rst = 1'b1;
        exp_q.delete();
        #1;
        total++;
        if (o_cen !== 1'b1 || o_rdata_valid !== 1'b0) begin
            bad++;
            $display("FAIL midrst_now: cen=%0b valid=%0b required 1 0", o_cen, o_rdata_valid);
        end
        tick();
        tick();
        rst = 1'b0;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (o_rdata_valid) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL midrst_stale: got %0d words required 0", seen);
        end
        tick();
    endtask

    task automatic test_stream();
        int first, last, nv, stalls;
        idle(4);
        first = -1;
        last = -1;
        nv = 0;
        stalls = 0;
        for (int i = 0; i < 72; i++) begin
            i_rd_valid = (i < 64);
            i_rd_addr = ADDR'(i);
            @(negedge clk);
            if (i < 64 && !o_rd_ready) stalls++;
            if (o_rdata_valid) begin
                if (first < 0) first = i;
                last = i;
                nv++;
            end
            tick();
        end
        total++;
        if (stalls != 0) begin
            bad++;
            $display("FAIL stream_accept: got %0d stalls required 0", stalls);
        end
        total++;
        if (nv != 64 || last - first != 63) begin
            bad++;
            $display("FAIL stream_return: got %0d words over %0d cycles required 64 over 64", nv, last - first + 1);
        end
        idle(4);
    endtask

    task automatic test_random();
        int outst;
        bit last_rd, rd_ok, ew, er;
        reset_dut();
        outst = 0;
        last_rd = 1'b1;
        for (int c = 0; c < 400; c++) begin
            i_wr_valid = 1'($urandom_range(0, 1));
            i_rd_valid = 1'($urandom_range(0, 1));
            i_rdata_ready = ($urandom_range(0, 3) != 0);
            i_wr_addr = ADDR'($urandom);
            i_rd_addr = ADDR'($urandom);
            i_wr_data = rnd_word();
            @(negedge clk);
            rd_ok = i_rd_valid && (outst < DEPTH);
            ew = i_wr_valid && (!rd_ok || last_rd);
            er = rd_ok && !ew;
            total++;
            if (o_wr_ready !== ew || o_rd_ready !== er) begin
                bad++;
                $display("FAIL rand_grant[%0d]: wr=%0b rd=%0b required %0b %0b", c, o_wr_ready, o_rd_ready, ew, er);
            end
            if (ew) last_rd = 1'b0;
            else if (er) last_rd = 1'b1;
            if (er) outst++;
            if (o_rdata_valid && i_rdata_ready) outst--;
            tick();
        end
        idle(10);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < WORDS; i++) begin
            sram[i] = rnd_word();
            shadow[i] = sram[i];
        end
        test_reset();
        test_basic();
        test_alternate();
        test_backpressure();
        test_raw();
        test_reset_mid();
        test_stream();
        test_random();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL leftover: got %0d pending words required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/nbin_sram_ctrl.md
NBIN_SRAM_CTRL -- requirements
Module: nbin_sram_ctrl

Interface
REQ-001 SHALL have parameter N, default 256, SRAM word width in bits.
REQ-002 SHALL have parameter ADDR, default 6, SRAM address width.
REQ-003 SHALL have parameter NUM_WORDS, default 64, SRAM depth.
REQ-004 SHALL have parameter RD_DEPTH, default 4, read-return FIFO depth.
REQ-005 SHALL have port clk  input  1  single clock; all logic on posedge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port i_wr_valid  input  1  write request valid.
REQ-008 SHALL have port o_wr_ready  output  1  write request accepted this cycle.
REQ-009 SHALL have port i_wr_addr  input  ADDR  write address.
REQ-010 SHALL have port i_wr_data  input  N  write data.
REQ-011 SHALL have port i_rd_valid  input  1  read request valid.
REQ-012 SHALL have port o_rd_ready  output  1  read request accepted this cycle.
REQ-013 SHALL have port i_rd_addr  input  ADDR  read address.
REQ-014 SHALL have port o_rdata_valid  output  1  read data valid.
REQ-015 SHALL have port i_rdata_ready  input  1  consumer accepts read data.
REQ-016 SHALL have port o_rdata  output  N  read data.
REQ-017 SHALL have port o_cen  output  1  SRAM chip enable, active-low, registered.
REQ-018 SHALL have port o_wen  output  1  SRAM write enable, active-low, registered.
REQ-019 SHALL have port o_a  output  ADDR  SRAM address, registered.
REQ-020 SHALL have port o_d  output  N  SRAM write data, registered.
REQ-021 SHALL have port i_q  input  N  SRAM read data, valid the cycle after the macro samples a read.

Function
REQ-022 SHALL issue at most one SRAM access per cycle (single-port macro); a request is accepted when valid and ready are both high at posedge.
REQ-023 SHALL deem a read eligible only when fifo_count + inflight < RD_DEPTH; inflight counts accepted reads not yet written to the FIFO (0..2).
REQ-024 SHALL grant the sole eligible requester; when both are eligible, SHALL grant the one opposite to last_grant; last_grant updates on every grant.
REQ-025 SHALL drive o_wr_ready/o_rd_ready combinationally from the grant decision, never both high.
REQ-026 SHALL, in the cycle after an accepted write, present o_cen=0, o_wen=0, o_a=addr, o_d=data; after an accepted read, o_cen=0, o_wen=1, o_a=addr; with no grant, o_cen=1, o_wen=1, o_a/o_d held.
REQ-027 SHALL capture i_q into the FIFO two cycles after the read command cycle; read acceptance at edge t gives o_rdata_valid no earlier than cycle t+3.
REQ-028 SHALL return read data in request order; o_rdata/o_rdata_valid SHALL hold stable while valid and not ready.
REQ-029 SHALL sustain one read per cycle when i_rdata_ready is held high and RD_DEPTH>=4.
REQ-030 SHALL give a read accepted after a write to the same address the newly written data.
REQ-031 SHALL handle a simultaneous FIFO push and pop without count change; FIFO overflow SHALL be impossible by REQ-023.

Reset
REQ-032 SHALL on rst force o_cen=1, o_wen=1, o_a=0, o_d=0, o_rdata_valid=0, FIFO empty, inflight=0, last_grant=read (first contended grant goes to write).
REQ-033 SHALL discard in-flight reads on reset mid-operation; no stale data SHALL appear after reset release.

Structure
REQ-034 SHALL take N, ADDR, NUM_WORDS, RD_DEPTH defaults from shared package nbin_pkg, also used by the NBin/NBout top wrappers.
REQ-035 SHALL instantiate one sub-module, nbin_rd_fifo (synchronous FIFO, depth RD_DEPTH, width N); arbitration, credit and SRAM-port registers stay in nbin_sram_ctrl.

Verification
REQ-036 Writes 0xA5..A5 @3, 0x5A..5A @7, then reads @3, @7 with ready high -> o_rdata 0xA5..A5 then 0x5A..5A, first valid 3 cycles after read accept.
REQ-037 Both valid continuously for 8 cycles -> grants W,R,W,R,W,R,W,R; o_wen toggles 0/1 each following cycle.
REQ-038 i_rdata_ready=0, 10 reads requested -> exactly 4 accepted, o_rd_ready low thereafter; ready=1 -> 4 words drain in order, reads resume.
REQ-039 Write @5 accepted at cycle t, read @5 accepted at t+1 -> returned data equals new write value.
REQ-040 rst asserted one cycle after two reads accepted -> o_cen=1, o_rdata_valid=0 immediately; neither word appears after release.
REQ-041 Back-to-back reads @0..63 with ready high -> 64 words in order, no bubbles after first return.
